// File: rtl/pwm_decoder_pkg.sv
// Shared definitions for the PWM decoder: FSM state encoding and pipeline timing.
package pwm_decoder_pkg;

    // Decoder FSM states: waiting for a low input, waiting for the first
    // rising edge, and measuring between consecutive rising edges.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_e;

    // Clock edges from the edge that samples pwm_in high to the edge that
    // raises valid: two synchronizer flops, the edge register and the
    // output register.
    localparam int VALID_LATENCY = 4;

    // Flop stages ahead of the FSM. After reset these must refill with real
    // samples of the pin before the synchronized level can be trusted.
    localparam int SYNC_FILL = VALID_LATENCY - 1;

endpackage

// File: rtl/pwm_decoder_sync_edge.sv
// Two-flop synchronizer for the asynchronous PWM input followed by a
// registered rising-edge detector. q and rise are aligned with each other:
// in the cycle where rise is high, q is already high.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic q,
    output logic rise
);

    logic sync1_q;
    logic sync2_q;
    logic level_q;
    logic rise_q;

    // Synchronize the pin, delay it once more and register its rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= d_in;
            sync2_q <= sync1_q;
            level_q <= sync2_q;
            rise_q  <= sync2_q & ~level_q;
        end
    end

    assign q    = level_q;
    assign rise = rise_q;

endmodule

// File: rtl/pwm_decoder.sv
// PWM decoder: measures the spacing between rising edges of pwm_in and the
// number of high cycles inside each period, with timeout and stale flags.
module pwm_decoder
    import pwm_decoder_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pwm_in,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic                 valid,
    output logic                 timeout,
    output logic                 stale
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};
    localparam logic [1:0]           SETTLE_DONE = 2'(SYNC_FILL);

    logic level;
    logic rise;

    state_e               state_q,     state_d;
    logic [1:0]           settle_q,    settle_d;
    logic [CNT_WIDTH-1:0] periodCnt_q, periodCnt_d;
    logic [CNT_WIDTH-1:0] highCnt_q,   highCnt_d;
    logic [CNT_WIDTH-1:0] period_q,    period_d;
    logic [CNT_WIDTH-1:0] highTime_q,  highTime_d;
    logic                 valid_q,     valid_d;
    logic                 timeout_q,   timeout_d;
    logic                 stale_q,     stale_d;

    logic settled;
    logic saturated;

    sync_edge u_sync_edge (
        .clk  (clk),
        .rst  (rst),
        .d_in (pwm_in),
        .q    (level),
        .rise (rise)
    );

    // Right after reset the synchronizer holds zeros rather than real pin
    // samples, so a pin that is already high would look low for a few
    // cycles and then produce a false edge. IDLE ignores the level until
    // the pipeline has refilled.
    assign settled   = (settle_q == SETTLE_DONE);
    assign saturated = (periodCnt_q == CNT_MAX);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a rising edge always beats counter saturation.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (settled && !level) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (rise) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (!rise && saturated) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values. The edge cycle counts as the first
    // (high) cycle of the new period, so the counters reload to one.
    always_comb begin
        settle_d    = settled ? settle_q : settle_q + 2'd1;
        periodCnt_d = periodCnt_q;
        highCnt_d   = highCnt_q;
        period_d    = period_q;
        highTime_d  = highTime_q;
        valid_d     = 1'b0;
        timeout_d   = 1'b0;
        stale_d     = stale_q;
        case (state_q)
            ARMED: begin
                if (rise) begin
                    periodCnt_d = CNT_ONE;
                    highCnt_d   = CNT_ONE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_d    = periodCnt_q;
                    highTime_d  = highCnt_q;
                    valid_d     = 1'b1;
                    stale_d     = 1'b0;
                    periodCnt_d = CNT_ONE;
                    highCnt_d   = CNT_ONE;
                end else if (saturated) begin
                    timeout_d   = 1'b1;
                    stale_d     = 1'b1;
                    periodCnt_d = '0;
                    highCnt_d   = '0;
                end else begin
                    periodCnt_d = periodCnt_q + CNT_ONE;
                    highCnt_d   = highCnt_q + CNT_WIDTH'(level);
                end
            end
            default: begin
            end
        endcase
    end

    // Counter, result and strobe registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_q    <= 2'd0;
            periodCnt_q <= '0;
            highCnt_q   <= '0;
            period_q    <= '0;
            highTime_q  <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            stale_q     <= 1'b0;
        end else begin
            settle_q    <= settle_d;
            periodCnt_q <= periodCnt_d;
            highCnt_q   <= highCnt_d;
            period_q    <= period_d;
            highTime_q  <= highTime_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
            stale_q     <= stale_d;
        end
    end

    assign period    = period_q;
    assign high_time = highTime_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;
    assign stale     = stale_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed testbench for pwm_decoder: a 16-bit instance for the measurement
// scenarios and an 8-bit instance for the timeout scenario.
module tb_pwm_decoder;

    logic        clk = 1'b0;
    logic        rst16;
    logic        rst8;
    logic        pwm16;
    logic        pwm8;
    logic [15:0] period16;
    logic [15:0] high16;
    logic        valid16;
    logic        timeout16;
    logic        stale16;
    logic [7:0]  period8;
    logic [7:0]  high8;
    logic        valid8;
    logic        timeout8;
    logic        stale8;

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int vCount16 = 0;
    int lastVCyc16 = 0;
    int spacing16 = 0;
    int lastP16 = 0;
    int lastH16 = 0;
    int lastRiseCyc16 = 0;
    int vCount8 = 0;
    int lastVCyc8 = 0;
    int tCount8 = 0;
    int tCyc8 = 0;
    int overlap = 0;
    int highOverPeriod = 0;
    int base;

    pwm_decoder #(.CNT_WIDTH(16)) dut16 (
        .clk       (clk),
        .rst       (rst16),
        .pwm_in    (pwm16),
        .period    (period16),
        .high_time (high16),
        .valid     (valid16),
        .timeout   (timeout16),
        .stale     (stale16)
    );

    pwm_decoder #(.CNT_WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst8),
        .pwm_in    (pwm8),
        .period    (period8),
        .high_time (high8),
        .valid     (valid8),
        .timeout   (timeout8),
        .stale     (stale8)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    // Count clock edges and log strobes shortly after each rising edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (valid16) begin
            vCount16   = vCount16 + 1;
            spacing16  = cyc - lastVCyc16;
            lastVCyc16 = cyc;
            lastP16    = int'(period16);
            lastH16    = int'(high16);
            if (high16 > period16) highOverPeriod = highOverPeriod + 1;
        end
        if (valid8) begin
            vCount8   = vCount8 + 1;
            lastVCyc8 = cyc;
            if (high8 > period8) highOverPeriod = highOverPeriod + 1;
        end
        if (timeout8) begin
            tCount8 = tCount8 + 1;
            tCyc8   = cyc;
        end
        if ((valid16 && timeout16) || (valid8 && timeout8)) overlap = overlap + 1;
    end

    // Drive reps periods of a PWM waveform, one sample per falling edge.
    task automatic applyStimulus(input int sel, input int high, input int per, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < per; i++) begin
                @(negedge clk);
                if (sel == 16) begin
                    pwm16 = (i < high);
                    if (i == 0) lastRiseCyc16 = cyc;
                end else begin
                    pwm8 = (i < high);
                end
            end
        end
    endtask

    // Hold the input at a constant level for n cycles.
    task automatic holdLevel(input int sel, input logic val, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sel == 16) pwm16 = val;
            else           pwm8  = val;
        end
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total = total + 1;
        assert (observed === expected)
        else begin
            bad = bad + 1;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Directed scenario sequence.
    initial begin
        rst16 = 1'b1;
        rst8  = 1'b1;
        pwm16 = 1'b0;
        pwm8  = 1'b0;
        holdLevel(16, 1'b0, 3);
        checkOutput("rst_period",  32'(period16),  32'd0);
        checkOutput("rst_high",    32'(high16),    32'd0);
        checkOutput("rst_valid",   32'(valid16),   32'd0);
        checkOutput("rst_timeout", 32'(timeout16), 32'd0);
        checkOutput("rst_stale",   32'(stale16),   32'd0);
        rst16 = 1'b0;
        rst8  = 1'b0;
        holdLevel(16, 1'b0, 6);

        $display("[TB] 50%% duty, 10-cycle period");
        base = vCount16;
        applyStimulus(16, 5, 10, 5);
        checkOutput("duty50_count",   32'(vCount16 - base),           32'd4);
        checkOutput("duty50_period",  32'(lastP16),                   32'd10);
        checkOutput("duty50_high",    32'(lastH16),                   32'd5);
        checkOutput("duty50_spacing", 32'(spacing16),                 32'd10);
        checkOutput("duty50_latency", 32'(lastVCyc16 - lastRiseCyc16), 32'd4);
        holdLevel(16, 1'b0, 6);

        $display("[TB] alternating input");
        base = vCount16;
        applyStimulus(16, 1, 2, 10);
        holdLevel(16, 1'b0, 4);
        checkOutput("alt_count",   32'(vCount16 - base), 32'd10);
        checkOutput("alt_period",  32'(lastP16),         32'd2);
        checkOutput("alt_high",    32'(lastH16),         32'd1);
        checkOutput("alt_spacing", 32'(spacing16),       32'd2);
        checkOutput("alt_stale",   32'(stale16),         32'd0);

        $display("[TB] duty change 30 to 70");
        applyStimulus(16, 30, 100, 3);
        applyStimulus(16, 70, 100, 1);
        checkOutput("duty30_period", 32'(period16), 32'd100);
        checkOutput("duty30_high",   32'(high16),   32'd30);
        applyStimulus(16, 70, 100, 1);
        checkOutput("duty70_period", 32'(period16), 32'd100);
        checkOutput("duty70_high",   32'(high16),   32'd70);
        holdLevel(16, 1'b0, 5);

        $display("[TB] reset in the middle of a 300-cycle period");
        applyStimulus(16, 150, 300, 2);
        checkOutput("p300_period", 32'(period16), 32'd300);
        checkOutput("p300_high",   32'(high16),   32'd150);
        holdLevel(16, 1'b1, 100);
        #2 rst16 = 1'b1;
        #1;
        checkOutput("async_rst_period", 32'(period16), 32'd0);
        checkOutput("async_rst_high",   32'(high16),   32'd0);
        checkOutput("async_rst_valid",  32'(valid16),  32'd0);
        checkOutput("async_rst_stale",  32'(stale16),  32'd0);
        pwm16 = 1'b0;
        holdLevel(16, 1'b0, 3);
        rst16 = 1'b0;
        holdLevel(16, 1'b0, 6);
        base = vCount16;
        applyStimulus(16, 150, 300, 1);
        checkOutput("resume_first_edge", 32'(vCount16 - base), 32'd0);
        applyStimulus(16, 150, 300, 2);
        holdLevel(16, 1'b0, 5);
        checkOutput("resume_count",  32'(vCount16 - base), 32'd2);
        checkOutput("resume_period", 32'(period16),        32'd300);
        checkOutput("resume_high",   32'(high16),          32'd150);

        $display("[TB] input high at reset release");
        rst16 = 1'b1;
        pwm16 = 1'b1;
        holdLevel(16, 1'b1, 3);
        rst16 = 1'b0;
        base = vCount16;
        holdLevel(16, 1'b1, 20);
        holdLevel(16, 1'b0, 10);
        applyStimulus(16, 7, 20, 1);
        checkOutput("hi_rel_no_valid", 32'(vCount16 - base), 32'd0);
        checkOutput("hi_rel_period0",  32'(period16),        32'd0);
        applyStimulus(16, 7, 20, 1);
        holdLevel(16, 1'b0, 5);
        checkOutput("hi_rel_count",  32'(vCount16 - base), 32'd1);
        checkOutput("hi_rel_period", 32'(period16),        32'd20);
        checkOutput("hi_rel_high",   32'(high16),          32'd7);

        $display("[TB] timeout with 8-bit counters");
        applyStimulus(8, 5, 12, 3);
        checkOutput("lock8_period", 32'(period8), 32'd12);
        checkOutput("lock8_high",   32'(high8),   32'd5);
        checkOutput("lock8_stale",  32'(stale8),  32'd0);
        base = vCount8;
        holdLevel(8, 1'b1, 300);
        checkOutput("to_valid_count", 32'(vCount8 - base),     32'd1);
        checkOutput("to_pulses",      32'(tCount8),            32'd1);
        checkOutput("to_delay",       32'(tCyc8 - lastVCyc8),  32'd255);
        checkOutput("to_stale",       32'(stale8),             32'd1);
        checkOutput("to_timeout_low", 32'(timeout8),           32'd0);
        checkOutput("to_hold_period", 32'(period8),            32'd12);
        checkOutput("to_hold_high",   32'(high8),              32'd5);
        base = vCount8;
        holdLevel(8, 1'b0, 10);
        applyStimulus(8, 8, 20, 1);
        holdLevel(8, 1'b1, 6);
        checkOutput("rec_count",  32'(vCount8 - base), 32'd1);
        checkOutput("rec_period", 32'(period8),        32'd20);
        checkOutput("rec_high",   32'(high8),          32'd8);
        checkOutput("rec_stale",  32'(stale8),         32'd0);

        checkOutput("no_valid_timeout_overlap", 32'(overlap),        32'd0);
        checkOutput("high_not_over_period",     32'(highOverPeriod), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
